// File: rtl/dff_down_counter.sv
// Loadable down-counter / countdown timer with a one-cycle done pulse.
// Optional auto-reload turns it into a periodic tick generator.
module dff_down_counter #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             done_q;
    logic             done_d;

    // State, count, reload value and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: abort beats terminal/decrement, which beats load.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        if (load_value != CNT_ZERO) begin
                            count_d  = load_value;
                            reload_d = load_value;
                            state_d  = ST_RUN;
                        end else begin
                            // A zero load completes immediately without entering RUN.
                            count_d = CNT_ZERO;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else if (count_q == CNT_ONE) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = CNT_ZERO;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            // Zero in RUN is unreachable; recover quietly without a pulse.
                            count_d = CNT_ZERO;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign count      = count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dff_down_counter.sv
// Directed, table-driven bench for dff_down_counter (plain and auto-reload instances).
module tb_dff_down_counter;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_value;
    logic       enable;
    logic       abort;

    logic       ready0, busy0, done0;
    logic [7:0] count0;
    logic       ready1, busy1, done1;
    logic [7:0] count1;

    int errors;
    int checks;

    dff_down_counter #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready0),
        .load_value(load_value), .enable(enable), .abort(abort),
        .count(count0), .busy(busy0), .done(done0)
    );

    dff_down_counter #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready1),
        .load_value(load_value), .enable(enable), .abort(abort),
        .count(count1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic [7:0] val;
        logic       en;
        logic       ab;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_done;
        logic       e_ready;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [7:0] val, input logic en, input logic ab);
        @(negedge clk);
        load_valid = lv;
        load_value = val;
        enable     = en;
        abort      = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        load_valid = 1'b0; load_value = 8'd0; enable = 1'b0; abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        load_valid = 1'b0; load_value = 8'd0; enable = 1'b0; abort = 1'b0;

        //          lv    val     en    ab    count  busy  done  ready
        vecs[0]  = '{1'b1, 8'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'd4, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 8'd7, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 8'd9, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 8'd9, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[23] = '{1'b1, 8'd9, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};

        // Reset state
        @(posedge clk); #1;
        check("rst_count", int'(count0), 0);
        check("rst_busy",  int'(busy0),  0);
        check("rst_done",  int'(done0),  0);
        check("rst_ready", int'(ready0), 1);
        @(negedge clk);
        reset = 1'b0;

        // Table: plain countdown, enable gaps, zero load, abort cases, ignored loads
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].lv, vecs[i].val, vecs[i].en, vecs[i].ab);
            check($sformatf("v%0d_count", i), int'(count0), int'(vecs[i].e_count));
            check($sformatf("v%0d_busy", i),  int'(busy0),  int'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i),  int'(done0),  int'(vecs[i].e_done));
            check($sformatf("v%0d_ready", i), int'(ready0), int'(vecs[i].e_ready));
        end

        // Asynchronous reset mid-RUN at count 5
        do_reset();
        drive(1'b1, 8'd10, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 8'd0, 1'b1, 1'b0);
        check("pre_rst_count", int'(count0), 5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_count", int'(count0), 0);
        check("async_rst_busy",  int'(busy0),  0);
        check("async_rst_ready", int'(ready0), 1);
        check("async_rst_done",  int'(done0),  0);

        // Auto-reload: load 2 -> 2,1,2,1..., done whenever reloaded to 2
        do_reset();
        drive(1'b1, 8'd2, 1'b1, 1'b0);
        check("ar_load_count", int'(count1), 2);
        check("ar_load_done",  int'(done1),  0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 8'd0, 1'b1, 1'b0);
            check($sformatf("ar_count_%0d", k), int'(count1), (k % 2 == 1) ? 1 : 2);
            check($sformatf("ar_done_%0d", k),  int'(done1),  (k % 2 == 1) ? 0 : 1);
            check($sformatf("ar_busy_%0d", k),  int'(busy1),  1);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        check("ar_pre_abort_count", int'(count1), 1);
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        check("ar_abort_count", int'(count1), 0);
        check("ar_abort_busy",  int'(busy1),  0);
        check("ar_abort_done",  int'(done1),  0);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        check("ar_post_abort_done",  int'(done1),  0);
        check("ar_post_abort_ready", int'(ready1), 1);

        // Max load 255 with load_valid held during RUN
        do_reset();
        drive(1'b1, 8'd255, 1'b1, 1'b0);
        check("max_load_count", int'(count0), 255);
        for (int k = 1; k <= 255; k++) begin
            drive(1'b1, 8'd7, 1'b1, 1'b0);
            check($sformatf("max_count_%0d", k), int'(count0), 255 - k);
            check($sformatf("max_done_%0d", k),  int'(done0),  (k == 255) ? 1 : 0);
        end
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        check("max_after_count", int'(count0), 0);
        check("max_after_done",  int'(done0),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
